// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns PS/2 set-2 scan bytes into 5-bit key-release command codes.
// Tracks the E0 (extended) and F0 (break) prefixes, translates each release via the
// normal or extended table and queues mapped codes in a first-word-fall-through FIFO.
// Optional build macro KEYDEC_TIMEOUT_EN: a stalled prefix sequence returns to IDLE
// after TIMEOUT_CYCLES clocks without a byte.
//
// state    | meaning
// ---------+-----------------------------------------------
// S_IDLE   | waiting for a prefix; plain bytes are makes
// S_EXT    | E0 seen, waiting for F0 or an extended make
// S_BRK    | F0 seen, next byte is the released key
// S_EXT_BRK| E0 F0 seen, next byte is the released ext key
module ps2_key_decoder #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_done_tick,
    input  logic [7:0] dout,
    input  logic       rd_en,
    output logic       key_valid,
    output logic [4:0] key_code,
    output logic       fifo_full,
    output logic       overflow
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    // Reject parameter sets the pointer arithmetic and timeout compare cannot handle.
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ps2_key_decoder: FIFO_DEPTH must be a power of 2 >= 2, TIMEOUT_CYCLES >= 2");
    end

    // {hit, code}; hit=0 means the byte has no command mapping
    function automatic logic [5:0] map_normal(input logic [7:0] b);
        case (b)
            8'h45:   map_normal = {1'b1, 5'h00};
            8'h16:   map_normal = {1'b1, 5'h01};
            8'h1E:   map_normal = {1'b1, 5'h02};
            8'h26:   map_normal = {1'b1, 5'h03};
            8'h25:   map_normal = {1'b1, 5'h04};
            8'h2E:   map_normal = {1'b1, 5'h05};
            8'h36:   map_normal = {1'b1, 5'h06};
            8'h3D:   map_normal = {1'b1, 5'h07};
            8'h3E:   map_normal = {1'b1, 5'h08};
            8'h46:   map_normal = {1'b1, 5'h09};
            8'h5A:   map_normal = {1'b1, 5'h14};
            8'h76:   map_normal = {1'b1, 5'h15};
            8'h2B:   map_normal = {1'b1, 5'h16};
            default: map_normal = {1'b0, 5'h00};
        endcase
    endfunction

    function automatic logic [5:0] map_ext(input logic [7:0] b);
        case (b)
            8'h75:   map_ext = {1'b1, 5'h10};
            8'h72:   map_ext = {1'b1, 5'h11};
            8'h6B:   map_ext = {1'b1, 5'h12};
            8'h74:   map_ext = {1'b1, 5'h13};
            default: map_ext = {1'b0, 5'h00};
        endcase
    endfunction

    state_t          state_q, state_d;
    logic            push;
    logic [4:0]      push_code;
    logic [5:0]      lookup;

    logic [4:0]      mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic            overflow_q;
    logic            do_push, do_pop;

`ifdef KEYDEC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0]   tmo_q;
    logic            tmo_hit;

    assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    // Prefix timeout counter: idle in S_IDLE, restarted by every received byte.
    always_ff @(posedge clk) begin
        if (reset || rx_done_tick || state_q == S_IDLE || tmo_hit) tmo_q <= '0;
        else                                                        tmo_q <= tmo_q + TW'(1);
    end
`endif

    // Prefix FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Prefix FSM next state and table lookup of the released key.
    always_comb begin
        state_d   = state_q;
        push      = 1'b0;
        push_code = 5'h00;
        lookup    = 6'h00;
        if (rx_done_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (dout == 8'hE0)      state_d = S_EXT;
                    else if (dout == 8'hF0) state_d = S_BRK;
                end
                S_EXT: begin
                    if (dout == 8'hF0) state_d = S_EXT_BRK;
                    else               state_d = S_IDLE;
                end
                S_BRK: begin
                    lookup    = map_normal(dout);
                    push      = lookup[5];
                    push_code = lookup[4:0];
                    state_d   = S_IDLE;
                end
                S_EXT_BRK: begin
                    lookup    = map_ext(dout);
                    push      = lookup[5];
                    push_code = lookup[4:0];
                    state_d   = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
`ifdef KEYDEC_TIMEOUT_EN
        else if (tmo_hit) begin
            state_d = S_IDLE;
        end
`endif
    end

    assign fifo_full = (count_q == CW'(FIFO_DEPTH));
    assign key_valid = (count_q != '0);
    assign do_pop    = rd_en && key_valid;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push   = push && (!fifo_full || do_pop);
    assign key_code  = key_valid ? mem_q[rd_ptr_q] : 5'h00;
    assign overflow  = overflow_q;

    // Event storage and pointers; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 5'h00;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_code;
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push && !do_push) overflow_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: release events are predicted into a queue as the
// break byte is sent and compared against the FIFO head as the queue is drained.
module tb_ps2_key_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] dout;
    logic       rd_en;
    logic       key_valid;
    logic [4:0] key_code;
    logic       fifo_full;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    ps2_key_decoder #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(100)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .dout         (dout),
        .rd_en        (rd_en),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .fifo_full    (fifo_full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // one-cycle strobe; returns on the negedge after the capturing posedge
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_done_tick = 1'b1;
        dout         = b;
        @(negedge clk);
        rx_done_tick = 1'b0;
        dout         = 8'h00;
    endtask

    task automatic send_release(input logic [7:0] b, input logic ext, input logic [4:0] code, input logic mapped);
        if (ext) send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(b);
        if (mapped) exp_q.push_back(code);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        logic [4:0] e;
        @(negedge clk);
        while (key_valid && n < 16) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL %s: unexpected event code=%02h, none expected", name, key_code);
            end else begin
                e = exp_q.pop_front();
                if (key_code !== e) begin
                    errors++;
                    $display("FAIL %s: key_code=%02h expected %02h", name, key_code, e);
                end
            end
            rd_en = 1'b1;
            @(negedge clk);
            rd_en = 1'b0;
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected events missing (got key_valid=%b)", name, exp_q.size(), key_valid);
            exp_q.delete();
        end
    endtask

    task automatic check_idle_outputs(input string name);
        checks++;
        if (key_valid !== 1'b0 || key_code !== 5'h00 || fifo_full !== 1'b0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL %s: valid=%b code=%02h full=%b ovf=%b expected 0 00 0 0",
                     name, key_valid, key_code, fifo_full, overflow);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        rx_done_tick = 1'b0;
        dout = 8'h00;
        rd_en = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_idle_outputs("reset");
    endtask

    task automatic test_latency();
        send_byte(8'hF0);
        checks++;
        if (key_valid !== 1'b0) begin
            errors++;
            $display("FAIL latency_prefix: key_valid=%b expected 0 after F0", key_valid);
        end
        send_byte(8'h2B);
        exp_q.push_back(5'h16);
        checks++;
        if (key_valid !== 1'b1 || key_code !== 5'h16) begin
            errors++;
            $display("FAIL latency: valid=%b code=%02h expected 1 16 one cycle after 2B", key_valid, key_code);
        end
        drain("latency");
    endtask

    task automatic test_repeat();
        send_byte(8'h2B);
        send_byte(8'h2B);
        send_release(8'h45, 1'b0, 5'h00, 1'b1);
        drain("repeat");
    endtask

    task automatic test_tables();
        logic [7:0] digits [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        for (int i = 0; i < 10; i++) begin
            send_release(digits[i], 1'b0, 5'(i), 1'b1);
            drain("digit");
        end
        send_release(8'h5A, 1'b0, 5'h14, 1'b1);
        send_release(8'h76, 1'b0, 5'h15, 1'b1);
        drain("enter_esc");
        send_release(8'h74, 1'b1, 5'h13, 1'b1);
        send_release(8'h75, 1'b1, 5'h10, 1'b1);
        send_release(8'h76, 1'b0, 5'h15, 1'b1);
        drain("ext_order");
        send_release(8'h72, 1'b1, 5'h11, 1'b1);
        send_release(8'h6B, 1'b1, 5'h12, 1'b1);
        drain("ext_down_left");
        // unmapped, ext make, ext code through normal table, normal code through ext table
        send_release(8'h1C, 1'b0, 5'h00, 1'b0);
        send_byte(8'hE0);
        send_byte(8'h6B);
        send_release(8'h74, 1'b0, 5'h00, 1'b0);
        send_release(8'h45, 1'b1, 5'h00, 1'b0);
        // F0 inside BRK is data: back to IDLE, so 45 is only a make
        send_byte(8'hF0);
        send_byte(8'hF0);
        send_byte(8'h45);
        drain("unmapped");
    endtask

    task automatic test_underflow();
        @(negedge clk);
        rd_en = 1'b1;
        repeat (3) @(negedge clk);
        rd_en = 1'b0;
        check_idle_outputs("underflow");
        send_release(8'h3E, 1'b0, 5'h08, 1'b1);
        drain("after_underflow");
    endtask

    task automatic test_overflow();
        logic [7:0] keys [4] = '{8'h45, 8'h16, 8'h1E, 8'h26};
        logic [4:0] e;
        for (int i = 0; i < 4; i++) send_release(keys[i], 1'b0, 5'(i), 1'b1);
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full4: full=%b ovf=%b expected 1 0", fifo_full, overflow);
        end
        send_release(8'h25, 1'b0, 5'h04, 1'b0);
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow: full=%b ovf=%b expected 1 1", fifo_full, overflow);
        end
        // push and pop in the same cycle while full
        send_byte(8'hF0);
        rx_done_tick = 1'b1;
        dout = 8'h2E;
        rd_en = 1'b1;
        e = exp_q.pop_front();
        checks++;
        if (key_code !== e) begin
            errors++;
            $display("FAIL pushpop_head: key_code=%02h expected %02h", key_code, e);
        end
        exp_q.push_back(5'h05);
        @(negedge clk);
        rx_done_tick = 1'b0;
        dout = 8'h00;
        rd_en = 1'b0;
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL pushpop_full: full=%b ovf=%b expected 1 1", fifo_full, overflow);
        end
        drain("overflow_drain");
        checks++;
        if (overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: ovf=%b expected 1", overflow);
        end
        pulse_reset();
        check_idle_outputs("overflow_cleared");
    endtask

    task automatic test_reset_mid();
        send_byte(8'hF0);
        pulse_reset();
        check_idle_outputs("reset_mid");
        send_byte(8'h16);
        check_idle_outputs("reset_mid_make");
        send_release(8'h16, 1'b0, 5'h01, 1'b1);
        drain("reset_mid_after");
    endtask

    task automatic test_timeout();
        send_byte(8'hF0);
        repeat (150) @(negedge clk);
        send_byte(8'h1E);
`ifndef KEYDEC_TIMEOUT_EN
        exp_q.push_back(5'h02);
`endif
        drain("timeout");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_latency();
        test_repeat();
        test_tables();
        test_underflow();
        test_overflow();
        test_reset_mid();
        test_timeout();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
